// File: rtl/clk_ratio_detector_if.sv
// Signal bundle for clk_ratio_detector: enable and measured input toward the
// detector, measurement results and status flags back to the consumer.
interface clk_ratio_detector_if #(
  parameter int MAX_RATIO = 64
);
  localparam int CW = $clog2(MAX_RATIO + 1);

  logic          en;
  logic          clk_in;
  logic [CW-1:0] ratio;
  logic [CW-1:0] high_cnt;
  logic          meas_valid;
  logic          locked;
  logic          err;

  modport master (
    output en,
    output clk_in,
    input  ratio,
    input  high_cnt,
    input  meas_valid,
    input  locked,
    input  err
  );

  modport slave (
    input  en,
    input  clk_in,
    output ratio,
    output high_cnt,
    output meas_valid,
    output locked,
    output err
  );
endinterface

// File: rtl/clk_ratio_detector.sv
// Measures period and high time of a slow clock-like input in clk cycles and tracks lock.
// Define CLK_RATIO_SYNC_EN to put a 2-flop synchronizer in front of clk_in (adds 2 cycles).
//
// state  | meaning
// IDLE   | disabled, counters held at 0
// ARM    | waiting for first rise, no capture, no timeout
// TRACK  | capturing periods, counting matching periods toward lock
// LOCKED | stable ratio; mismatch or timeout drops lock
module clk_ratio_detector #(
  parameter int MAX_RATIO  = 64,
  parameter int LOCK_COUNT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  clk_ratio_detector_if.slave  bus
);

  localparam int CW = $clog2(MAX_RATIO + 1);
  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam logic [CW-1:0] MAX_C  = CW'(MAX_RATIO);
  localparam logic [MW:0]   LOCK_C = (MW+1)'(LOCK_COUNT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    TRACK  = 2'd2,
    LOCKED = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          s, s_d;
  logic          rise, fall, timeout;
  logic [CW-1:0] pcnt_q, pcnt_d;
  logic [CW-1:0] hcnt_q, hcnt_d;
  logic [MW-1:0] mcnt_q, mcnt_d;
  logic [MW:0]   m_next;
  logic          lock_hit;
  logic [CW-1:0] ratio_q, ratio_d;
  logic [CW-1:0] high_q, high_d;
  logic          meas_valid_q, meas_valid_d;
  logic          locked_q, locked_d;
  logic          err_q, err_d;

`ifdef CLK_RATIO_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], bus.clk_in};
  end

  assign s = sync_q[1];
`else
  assign s = bus.clk_in;
`endif

  assign rise    = s & ~s_d;
  assign fall    = ~s & s_d;
  assign timeout = (pcnt_q == MAX_C) && !rise;

  // A run of matching periods only extends when the previous capture counted
  assign m_next   = ((pcnt_q == ratio_q) && (mcnt_q != '0)) ?
                    ({1'b0, mcnt_q} + 1'b1) : (MW+1)'(1);
  assign lock_hit = (m_next >= LOCK_C);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    mcnt_d       = mcnt_q;
    ratio_d      = ratio_q;
    high_d       = high_q;
    meas_valid_d = 1'b0;
    err_d        = 1'b0;
    locked_d     = locked_q;
    pcnt_d       = '0;
    hcnt_d       = '0;

    if (bus.en && (state_q != IDLE)) begin
      if (rise)                 pcnt_d = CW'(1);
      else if (pcnt_q == MAX_C) pcnt_d = pcnt_q;
      else                      pcnt_d = pcnt_q + 1'b1;

      if (rise)                          hcnt_d = CW'(1);
      else if (s && (hcnt_q != MAX_C))   hcnt_d = hcnt_q + 1'b1;
      else                               hcnt_d = hcnt_q;
    end

    if (!bus.en) begin
      state_d  = IDLE;
      locked_d = 1'b0;
      mcnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ARM;
          mcnt_d  = '0;
        end
        ARM: begin
          if (rise) begin
            state_d = TRACK;
            mcnt_d  = '0;
          end
        end
        TRACK: begin
          if (fall) high_d = hcnt_q;
          if (rise) begin
            ratio_d      = pcnt_q;
            meas_valid_d = 1'b1;
            if (lock_hit) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
              mcnt_d   = MW'(LOCK_COUNT);
            end else begin
              mcnt_d = m_next[MW-1:0];
            end
          end else if (timeout) begin
            err_d    = 1'b1;
            locked_d = 1'b0;
            mcnt_d   = '0;
            state_d  = ARM;
          end
        end
        LOCKED: begin
          if (fall) high_d = hcnt_q;
          if (rise) begin
            ratio_d      = pcnt_q;
            meas_valid_d = 1'b1;
            if (pcnt_q != ratio_q) begin
              err_d    = 1'b1;
              locked_d = 1'b0;
              mcnt_d   = MW'(1);
              state_d  = TRACK;
            end
          end else if (timeout) begin
            err_d    = 1'b1;
            locked_d = 1'b0;
            mcnt_d   = '0;
            state_d  = ARM;
          end
        end
        default: begin
          state_d  = IDLE;
          locked_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_d          <= 1'b0;
      pcnt_q       <= '0;
      hcnt_q       <= '0;
      mcnt_q       <= '0;
      ratio_q      <= '0;
      high_q       <= '0;
      meas_valid_q <= 1'b0;
      locked_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      s_d          <= s;
      pcnt_q       <= pcnt_d;
      hcnt_q       <= hcnt_d;
      mcnt_q       <= mcnt_d;
      ratio_q      <= ratio_d;
      high_q       <= high_d;
      meas_valid_q <= meas_valid_d;
      locked_q     <= locked_d;
      err_q        <= err_d;
    end
  end

  assign bus.ratio      = ratio_q;
  assign bus.high_cnt   = high_q;
  assign bus.meas_valid = meas_valid_q;
  assign bus.locked     = locked_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_clk_ratio_detector.sv
// Directed bench for clk_ratio_detector (default build, clk_in synchronous to clk).
module tb_clk_ratio_detector;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   mv_cnt;
  int   err_cnt;
  logic r_mv, r_locked, r_err;
  logic [6:0] r_ratio;

  clk_ratio_detector_if #(.MAX_RATIO(64)) bus ();

  clk_ratio_detector #(.MAX_RATIO(64), .LOCK_COUNT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // one clk cycle with clk_in = v; outputs sampled 1 time unit after the edge
  task automatic step(input logic v);
    bus.clk_in = v;
    @(posedge clk);
    #1;
    if (bus.meas_valid === 1'b1) mv_cnt++;
    if (bus.err === 1'b1) err_cnt++;
  endtask

  // one clk_in period starting with a rise; outputs after the rise cycle are kept
  task automatic period(input int h, input int l);
    step(1'b1);
    r_mv     = bus.meas_valid;
    r_ratio  = bus.ratio;
    r_locked = bus.locked;
    r_err    = bus.err;
    for (int i = 1; i < h; i++) step(1'b1);
    for (int i = 0; i < l; i++) step(1'b0);
  endtask

  task automatic restart();
    bus.en = 1'b0;
    step(1'b0);
    bus.en = 1'b1;
    step(1'b0);
  endtask

  // five periods from ARM: first rise silent, rises 2..5 measure, lock on the 5th
  task automatic lock_seq(input int h, input int l, input int exp_ratio,
                          input int exp_high, input string nm);
    err_cnt = 0;
    for (int k = 1; k <= 5; k++) begin
      period(h, l);
      if (k == 1) begin
        total++;
        if (r_mv !== 1'b0) begin
          bad++; $display("FAIL %s arm_rise_mv: got %0b want 0", nm, r_mv);
        end
      end else begin
        total++;
        if (r_mv !== 1'b1) begin
          bad++; $display("FAIL %s mv_rise%0d: got %0b want 1", nm, k, r_mv);
        end
        total++;
        if (r_ratio !== 7'(exp_ratio)) begin
          bad++; $display("FAIL %s ratio_rise%0d: got %0d want %0d", nm, k, r_ratio, exp_ratio);
        end
        total++;
        if (r_locked !== ((k == 5) ? 1'b1 : 1'b0)) begin
          bad++; $display("FAIL %s locked_rise%0d: got %0b want %0b", nm, k, r_locked, (k == 5));
        end
      end
    end
    total++;
    if (err_cnt != 0) begin
      bad++; $display("FAIL %s err_pulses: got %0d want 0", nm, err_cnt);
    end
    total++;
    if (bus.high_cnt !== 7'(exp_high)) begin
      bad++; $display("FAIL %s high_cnt: got %0d want %0d", nm, bus.high_cnt, exp_high);
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    bus.en     = 1'b0;
    bus.clk_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({bus.ratio, bus.high_cnt, bus.meas_valid, bus.locked, bus.err} !== 17'd0) begin
      bad++; $display("FAIL reset_outputs: got r=%0d h=%0d mv=%0b lk=%0b e=%0b want all 0",
                      bus.ratio, bus.high_cnt, bus.meas_valid, bus.locked, bus.err);
    end
    rst_n = 1'b1;
    step(1'b0);
  endtask

  task automatic test_lock_steady();
    bus.en = 1'b1;
    step(1'b0);
    lock_seq(2, 3, 5, 2, "steady");
  endtask

  task automatic test_ratio_change();
    err_cnt = 0;
    period(3, 4);
    total++;
    if (r_mv !== 1'b1 || r_ratio !== 7'd5 || r_locked !== 1'b1 || r_err !== 1'b0) begin
      bad++; $display("FAIL change_tail5: got mv=%0b r=%0d lk=%0b e=%0b want 1 5 1 0",
                      r_mv, r_ratio, r_locked, r_err);
    end
    period(3, 4);
    total++;
    if (r_mv !== 1'b1 || r_ratio !== 7'd7 || r_locked !== 1'b0 || r_err !== 1'b1) begin
      bad++; $display("FAIL change_first7: got mv=%0b r=%0d lk=%0b e=%0b want 1 7 0 1",
                      r_mv, r_ratio, r_locked, r_err);
    end
    for (int k = 3; k <= 5; k++) begin
      period(3, 4);
      total++;
      if (r_locked !== ((k == 5) ? 1'b1 : 1'b0) || r_err !== 1'b0 || r_ratio !== 7'd7) begin
        bad++; $display("FAIL change_relock%0d: got lk=%0b e=%0b r=%0d want lk=%0b e=0 r=7",
                        k, r_locked, r_err, r_ratio, (k == 5));
      end
    end
    total++;
    if (err_cnt != 1) begin
      bad++; $display("FAIL change_err_count: got %0d want 1", err_cnt);
    end
    total++;
    if (bus.high_cnt !== 7'd3) begin
      bad++; $display("FAIL change_high: got %0d want 3", bus.high_cnt);
    end
  endtask

  task automatic test_timeout();
    int first_err;
    logic lk_at_err;
    restart();
    lock_seq(2, 3, 5, 2, "tmo_lock");
    first_err = 0;
    lk_at_err = 1'b1;
    for (int j = 1; j <= 100 && first_err == 0; j++) begin
      step(1'b0);
      if (bus.err === 1'b1) begin
        first_err = j;
        lk_at_err = bus.locked;
      end
    end
    total++;
    if (first_err != 60) begin
      bad++; $display("FAIL timeout_cycle: got %0d want 60", first_err);
    end
    total++;
    if (lk_at_err !== 1'b0) begin
      bad++; $display("FAIL timeout_locked: got %0b want 0", lk_at_err);
    end
    step(1'b0);
    total++;
    if (bus.err !== 1'b0) begin
      bad++; $display("FAIL timeout_err_pulse: got %0b want 0", bus.err);
    end
    period(3, 3);
    total++;
    if (r_mv !== 1'b0) begin
      bad++; $display("FAIL timeout_arm_rise: got mv=%0b want 0", r_mv);
    end
    period(3, 3);
    total++;
    if (r_mv !== 1'b1 || r_ratio !== 7'd6) begin
      bad++; $display("FAIL timeout_remeasure: got mv=%0b r=%0d want 1 6", r_mv, r_ratio);
    end
  endtask

  task automatic test_min_max();
    restart();
    lock_seq(1, 1, 2, 1, "min");
    restart();
    lock_seq(32, 32, 64, 32, "max");
  endtask

  task automatic test_en_drop();
    restart();
    lock_seq(2, 3, 5, 2, "endrop_lock");
    mv_cnt  = 0;
    err_cnt = 0;
    bus.en  = 1'b0;
    step(1'b1);
    total++;
    if (bus.locked !== 1'b0 || bus.meas_valid !== 1'b0 || bus.ratio !== 7'd5) begin
      bad++; $display("FAIL endrop_cycle: got lk=%0b mv=%0b r=%0d want 0 0 5",
                      bus.locked, bus.meas_valid, bus.ratio);
    end
    step(1'b1);
    for (int i = 0; i < 3; i++) step(1'b0);
    total++;
    if (mv_cnt != 0 || err_cnt != 0 || bus.high_cnt !== 7'd2) begin
      bad++; $display("FAIL endrop_quiet: got mv=%0d e=%0d h=%0d want 0 0 2",
                      mv_cnt, err_cnt, bus.high_cnt);
    end
    bus.en = 1'b1;
    step(1'b0);
    lock_seq(2, 3, 5, 2, "endrop_relock");
  endtask

  task automatic test_reset_mid();
    restart();
    lock_seq(3, 3, 6, 3, "rstmid_lock");
    step(1'b1);
    step(1'b1);
    step(1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if ({bus.ratio, bus.high_cnt, bus.meas_valid, bus.locked, bus.err} !== 17'd0) begin
      bad++; $display("FAIL rstmid_outputs: got r=%0d h=%0d mv=%0b lk=%0b e=%0b want all 0",
                      bus.ratio, bus.high_cnt, bus.meas_valid, bus.locked, bus.err);
    end
    #2;
    rst_n = 1'b1;
    step(1'b0);
    lock_seq(2, 3, 5, 2, "rstmid_after");
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    mv_cnt  = 0;
    err_cnt = 0;
    test_reset();
    test_lock_steady();
    test_ratio_change();
    test_timeout();
    test_min_max();
    test_en_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
